// File: rtl/ibus_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// ibus_sram_responder_pkg
//   Shared pipeline types for the instruction bus (valid/addr_ok/data_ok
//   protocol) plus the definitions private to the SRAM responder.
//
//   ibus_req_t   : request from the fetch stage  (valid, addr[31:0])
//   ibus_resp_t  : response to the fetch stage   (addr_ok, data_ok, data[31:0])
//   resp_state_t : responder sequencing states   (IDLE, WAIT, RESP)
// ---------------------------------------------------------------------------
package ibus_sram_responder_pkg;

    // Fetch-side request. addr is a byte address; only word granularity is
    // meaningful to the instruction memory.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    // Responder-side reply. addr_ok acknowledges the request phase, data_ok
    // marks the single cycle in which data carries the fetched word.
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    // IDLE : waiting for a queued request
    // WAIT : burning the configured extra latency before the SRAM read
    // RESP : SRAM data is on sram_rdata, hand it back and retire the head
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Largest supported extra latency and the width of the counter that
    // counts it down.
    localparam int unsigned MAX_LATENCY  = 15;
    localparam int          LAT_CNT_W    = 4;

    // Counter reload value for a given latency (latency >= 1 when used).
    function automatic logic [LAT_CNT_W-1:0] lat_reload(input int unsigned latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/ibus_sram_responder_fifo.sv
// ---------------------------------------------------------------------------
// ibus_addr_fifo
//   Small in-order FIFO of request addresses (DEPTH x DW). Pushes into a full
//   FIFO and pops from an empty FIFO are ignored, so a push and a pop in the
//   same cycle on a full FIFO only pops. The head entry is visible
//   combinationally whenever the FIFO is non-empty.
//
//   clk       in   clock, all state on posedge
//   reset     in   asynchronous active-high reset, empties the FIFO
//   push      in   write push_data at the tail
//   push_data in   DW-bit entry
//   pop       in   retire the head entry
//   head      out  oldest entry (meaningless when empty)
//   count     out  number of valid entries, $clog2(DEPTH)+1 bits
//   full      out  count == DEPTH
//   empty     out  count == 0
// ---------------------------------------------------------------------------
module ibus_addr_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    // Pointer width never collapses to zero bits, even for DEPTH == 1.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic push_ok;
    logic pop_ok;

    // Wrap modulo DEPTH without requiring the pointer width to match exactly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: entries are only read while count says valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/ibus_sram_responder.sv
// ---------------------------------------------------------------------------
// ibus_sram_responder
//   Slave end of the instruction bus. Accepts in-order read requests into an
//   address FIFO, reads a synchronous single-port instruction SRAM for the
//   head request after LATENCY extra cycles, and returns one data_ok pulse
//   per accepted request in acceptance order.
//
//   clk        in   clock, all state on posedge
//   reset      in   asynchronous active-high reset; drops outstanding requests
//   ireq       in   fetch request (valid, byte addr)
//   iresp      out  addr_ok / data_ok / data
//   sram_en    out  SRAM read enable, high only in the issue cycle
//   sram_addr  out  SRAM word index of the head request (0 when idle/empty)
//   sram_rdata in   SRAM read data, valid the cycle after sram_en
//
//   Parameters: DEPTH   max outstanding requests (power of 2, >= 1)
//               LATENCY extra wait cycles before each SRAM read (0..15)
//               AW      SRAM word-address width (1..30)
// ---------------------------------------------------------------------------
module ibus_sram_responder
    import ibus_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 0,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  ibus_req_t     ireq,
    output ibus_resp_t    iresp,
    output logic          sram_en,
    output logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    resp_state_t          state_reg;
    resp_state_t          state_next;
    logic [LAT_CNT_W-1:0] cnt_reg;
    logic [LAT_CNT_W-1:0] cnt_next;

    logic          addr_ok;
    logic          accept;
    logic          fifo_pop;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          head_unused;

    logic          data_ok_c;
    logic [31:0]   data_c;

    // Acceptance depends on occupancy only. The count seen here is the value
    // before any pop in this cycle, so a full FIFO does not accept during
    // its RESP cycle.
    assign addr_ok = (fifo_count < CW'(DEPTH));
    assign accept  = ireq.valid && addr_ok;

    ibus_addr_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) u_addr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (ireq.addr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full_unused),
        .empty     (fifo_empty)
    );

    // Byte offset and bits above the SRAM size are dropped, so the memory
    // wraps. Keep the index at 0 when nothing is queued.
    assign sram_addr   = fifo_empty ? '0 : fifo_head[AW+1:2];
    assign head_unused = ^fifo_head;

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sram_en    = 1'b0;
        fifo_pop   = 1'b0;
        data_ok_c  = 1'b0;
        data_c     = '0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    if (LATENCY == 0) begin
                        sram_en    = 1'b1;
                        state_next = RESP;
                    end else begin
                        // WAIT spends cnt+1 cycles, the last of which issues.
                        cnt_next   = lat_reload(LATENCY);
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    sram_en    = 1'b1;
                    state_next = RESP;
                end
            end

            RESP: begin
                // SRAM output is valid exactly one cycle after the issue.
                data_ok_c  = 1'b1;
                data_c     = sram_rdata;
                fifo_pop   = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign iresp = '{addr_ok: addr_ok, data_ok: data_ok_c, data: data_c};

endmodule
